// File: rtl/port_out_uart_tx.sv
// Output-port peripheral: buffers 32-bit words written by the core in a small FIFO
// and shifts each one out as four 8N1 byte frames (byte 0 first) on TxSerial.
module port_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PortOutData,
  input  logic        PortOutWrite,
  output logic        Full,
  output logic        Overflow,
  output logic        Busy,
  output logic        TxSerial
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          stateReg, stateNext;
  logic [TW-1:0]   timerReg, timerNext;
  logic [2:0]      bitIdxReg, bitIdxNext;
  logic [1:0]      byteIdxReg, byteIdxNext;
  logic [31:0]     shiftReg;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count, countNext;
  logic            push, pop, shiftByte, fifoEmpty, timerDone;

  // A write while full is dropped even if a pop happens on the same edge.
  assign push      = PortOutWrite && !Full;
  assign fifoEmpty = (count == '0);
  assign timerDone = (timerReg == TIMER_LAST);
  assign countNext = count + CW'(push) - CW'(pop);

  always_comb begin
    stateNext   = stateReg;
    timerNext   = timerReg + TW'(1);
    bitIdxNext  = bitIdxReg;
    byteIdxNext = byteIdxReg;
    pop         = 1'b0;
    shiftByte   = 1'b0;
    case (stateReg)
      IDLE: begin
        timerNext = '0;
        if (!fifoEmpty) begin
          pop         = 1'b1;
          byteIdxNext = '0;
          stateNext   = START;
        end
      end
      START: begin
        if (timerDone) begin
          timerNext  = '0;
          bitIdxNext = '0;
          stateNext  = DATA;
        end
      end
      DATA: begin
        if (timerDone) begin
          timerNext = '0;
          if (bitIdxReg == 3'd7) stateNext = STOP;
          else bitIdxNext = bitIdxReg + 3'd1;
        end
      end
      STOP: begin
        if (timerDone) begin
          timerNext = '0;
          if (byteIdxReg != 2'd3) begin
            byteIdxNext = byteIdxReg + 2'd1;
            shiftByte   = 1'b1;
            stateNext   = START;
          end else if (!fifoEmpty) begin
            pop         = 1'b1;
            byteIdxNext = '0;
            stateNext   = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      timerReg   <= '0;
      bitIdxReg  <= '0;
      byteIdxReg <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      Full       <= 1'b0;
      Overflow   <= 1'b0;
      Busy       <= 1'b0;
      TxSerial   <= 1'b1;
    end else begin
      stateReg   <= stateNext;
      timerReg   <= timerNext;
      bitIdxReg  <= bitIdxNext;
      byteIdxReg <= byteIdxNext;
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      count <= countNext;
      Full  <= (countNext == COUNT_FULL);
      Busy  <= (stateNext != IDLE) || (countNext != '0);
      if (PortOutWrite && Full) Overflow <= 1'b1;
      // Line level follows the current state, so it lags a state change by one edge.
      case (stateReg)
        START:   TxSerial <= 1'b0;
        DATA:    TxSerial <= shiftReg[bitIdxReg];
        default: TxSerial <= 1'b1;
      endcase
    end
  end

  // FIFO storage and word shifter; the registered read lands directly in shiftReg.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= PortOutData;
    if (pop) shiftReg <= mem[rdPtr];
    else if (shiftByte) shiftReg <= {8'h00, shiftReg[31:8]};
  end

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Bench for port_out_uart_tx: directed scenarios plus random traffic, checked every
// cycle against a word-level timing model of the FIFO and serial line.
module tb_port_out_uart_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int WORD_CYC = 40 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PortOutData = '0;
  logic        PortOutWrite = 1'b0;
  logic        Full, Overflow, Busy, TxSerial;

  port_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .PortOutData(PortOutData),
    .PortOutWrite(PortOutWrite),
    .Full(Full),
    .Overflow(Overflow),
    .Busy(Busy),
    .TxSerial(TxSerial)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          pushT;
    int          popT;
  } word_t;

  word_t words[$];
  int    t = 0;
  int    lastPop = -100000;
  bit    ovfModel = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, t, obs, exp);
    end
  endtask

  // Words still held in the FIFO after edge e.
  function automatic int occAfter(input int e);
    int n = 0;
    foreach (words[i]) if (words[i].popT > e) n++;
    return n;
  endfunction

  // Word popped at edge P drives the line from edge P+1 for 40 bit-times.
  function automatic logic expTx(input int e);
    foreach (words[i]) begin
      int o = e - words[i].popT - 1;
      if (o >= 0 && o < WORD_CYC) begin
        int b = o / (10 * CPB);
        int s = (o % (10 * CPB)) / CPB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return words[i].data[8 * b + s - 1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic expBusy(input int e);
    foreach (words[i]) if (e < words[i].popT + WORD_CYC) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit wr, input logic [31:0] d, input bit rst);
    word_t w;
    PortOutWrite = wr;
    PortOutData  = d;
    reset        = rst;
    @(posedge clk);
    t++;
    if (rst) begin
      words.delete();
      lastPop  = -100000;
      ovfModel = 1'b0;
    end else if (wr) begin
      if (occAfter(t - 1) == DEPTH) begin
        ovfModel = 1'b1;
        $display("write cycle=%0d data=%h dropped (full)", t, d);
      end else begin
        w.data  = d;
        w.pushT = t;
        w.popT  = (t + 1 > lastPop + WORD_CYC) ? t + 1 : lastPop + WORD_CYC;
        lastPop = w.popT;
        words.push_back(w);
        $display("write cycle=%0d data=%h accepted, expected pop at %0d", t, d, w.popT);
      end
    end
    while (words.size() > 0 && t >= words[0].popT + 1 + WORD_CYC) void'(words.pop_front());
    #1;
    checkVal("tx", 32'(TxSerial), 32'(expTx(t)));
    checkVal("full", 32'(Full), 32'(occAfter(t) == DEPTH));
    checkVal("busy", 32'(Busy), 32'(expBusy(t)));
    checkVal("overflow", 32'(Overflow), 32'(ovfModel));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    idle(3);

    // Single word
    step(1'b1, 32'h0000_00A5, 1'b0);
    idle(180);

    // Reset mid-frame
    step(1'b1, 32'h0000_00A5, 1'b0);
    idle(9);
    step(1'b0, 32'h0, 1'b1);
    idle(60);

    // Byte order
    step(1'b1, 32'h4433_2211, 1'b0);
    idle(170);

    // Back-to-back words
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 32'h0123_4567, 1'b0);
    idle(330);

    // Overflow: six consecutive writes
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0);
    idle(5 * WORD_CYC + 20);
    step(1'b0, 32'h0, 1'b1);
    idle(5);

    // Pointer wrap: nine spaced words
    for (int i = 0; i < 9; i++) begin
      step(1'b1, $urandom, 1'b0);
      idle($urandom_range(120, 200));
    end
    idle(WORD_CYC);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 1499) == 0);
    idle(5 * WORD_CYC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
